// File: rtl/sopc_system_avalon_st_packet_arbiter_pkg.sv
// Shared payload widths, FSM encodings and beat record for the avalon_st adapter family.
package sopc_system_avalon_st_packet_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int ERR_W   = 6;
  localparam int EMPTY_W = 2;
  localparam int CH_W    = 2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [ERR_W-1:0]   error;
    logic [EMPTY_W-1:0] empty;
    logic               sop;
    logic               eop;
  } beat_t;

  // Channel after ch, wrapping num_in-1 back to 0.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch, input int num_in);
    return (int'(ch) == num_in - 1) ? '0 : ch + 1'b1;
  endfunction

endpackage

// File: rtl/sopc_system_avalon_st_packet_arbiter_rr.sv
// Round-robin grant search: first asserted valid at or after rr_ptr, wrapping to 0.
module sopc_system_avalon_st_packet_arbiter_rr
  import sopc_system_avalon_st_packet_arbiter_pkg::*;
#(
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN-1:0] in_valid,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [CH_W-1:0]   grant,
  output logic              found
);

  // Unrolled over every pointer value so all valid-bit selects are constant.
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    for (int p = 0; p < NUM_IN; p++) begin
      if (int'(rr_ptr) == p) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (!found && in_valid[(p + i) % NUM_IN]) begin
            grant = CH_W'((p + i) % NUM_IN);
            found = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sopc_system_avalon_st_packet_arbiter.sv
// Packet-level Avalon-ST arbiter: round-robin between inputs, grant held for a whole
// packet, single registered output stage sustaining one beat per cycle.
module sopc_system_avalon_st_packet_arbiter
  import sopc_system_avalon_st_packet_arbiter_pkg::*;
#(
  parameter int NUM_IN = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN*ERR_W-1:0]   in_error,
  input  logic [NUM_IN-1:0]         in_startofpacket,
  input  logic [NUM_IN-1:0]         in_endofpacket,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ERR_W-1:0]          out_error,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic [CH_W-1:0]           out_channel,
  output logic                      protocol_err
);

  // state     | meaning
  // ST_IDLE   | no packet owner, round-robin search selects the next input
  // ST_LOCKED | owner_q holds the grant until its EOP beat is accepted

  logic [0:0]      state_q, state_d;
  logic [CH_W-1:0] owner_q, owner_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0] out_channel_q, out_channel_d;
  logic            out_valid_q, out_valid_d;
  logic            protocol_err_q, protocol_err_d;
  beat_t           out_beat_q, out_beat_d;

  beat_t           beat_in;
  logic [CH_W-1:0] rr_grant, sel;
  logic            rr_found, sel_ok, slot_free, accept;

  sopc_system_avalon_st_packet_arbiter_rr #(.NUM_IN(NUM_IN)) u_rr (
    .in_valid (in_valid),
    .rr_ptr   (rr_ptr_q),
    .grant    (rr_grant),
    .found    (rr_found)
  );

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    sel       = (state_q == ST_LOCKED) ? owner_q : rr_grant;
    sel_ok    = (state_q == ST_LOCKED) || rr_found;
    in_ready  = '0;
    beat_in   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == CH_W'(k)) begin
        in_ready[k]   = sel_ok && slot_free && !reset;
        beat_in.data  = in_data[k*DATA_W +: DATA_W];
        beat_in.error = in_error[k*ERR_W +: ERR_W];
        beat_in.empty = in_empty[k*EMPTY_W +: EMPTY_W];
        beat_in.sop   = in_startofpacket[k];
        beat_in.eop   = in_endofpacket[k];
      end
    end
    accept = |(in_ready & in_valid);

    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    out_valid_d    = out_valid_q;
    out_beat_d     = out_beat_q;
    out_channel_d  = out_channel_q;
    protocol_err_d = protocol_err_q;

    if (accept) begin
      out_valid_d   = 1'b1;
      out_beat_d    = beat_in;
      out_channel_d = sel;
      // Framing errors are flagged but the beat still goes through.
      if ((state_q == ST_LOCKED && beat_in.sop) || (state_q == ST_IDLE && !beat_in.sop))
        protocol_err_d = 1'b1;
      if (beat_in.eop) begin
        state_d  = ST_IDLE;
        rr_ptr_d = next_ch(sel, NUM_IN);
      end else begin
        state_d = ST_LOCKED;
        owner_d = sel;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      out_beat_q     <= '0;
      out_channel_q  <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      out_valid_q    <= out_valid_d;
      out_beat_q     <= out_beat_d;
      out_channel_q  <= out_channel_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_beat_q.data;
  assign out_error         = out_beat_q.error;
  assign out_empty         = out_beat_q.empty;
  assign out_startofpacket = out_beat_q.sop;
  assign out_endofpacket   = out_beat_q.eop;
  assign out_channel       = out_channel_q;
  assign protocol_err      = protocol_err_q;

endmodule

// File: tb/tb_sopc_system_avalon_st_packet_arbiter.sv
// Self-checking bench: packet-level reference model plus directed scenarios on a 4-input arbiter.
module tb_sopc_system_avalon_st_packet_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  err;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
  } tbeat_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*32-1:0] in_data;
  logic [N*6-1:0] in_error;
  logic [N-1:0]   in_sop, in_eop;
  logic [N*2-1:0] in_empty;
  logic           out_ready;
  logic           out_valid;
  logic [31:0]    out_data;
  logic [5:0]     out_error;
  logic           out_sop, out_eop;
  logic [1:0]     out_empty;
  logic [1:0]     out_channel;
  logic           protocol_err;

  sopc_system_avalon_st_packet_arbiter #(.NUM_IN(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_error          (in_error),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_error         (out_error),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_empty         (out_empty),
    .out_channel       (out_channel),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Source side: one queue of beats per input, head presented while non-empty.
  tbeat_t srcq [N][$];
  logic [N-1:0] drv_fire = '0;
  logic ordy_next = 1'b1;

  function automatic tbeat_t mk(int ch, int pkt, int idx, bit sop, bit eop);
    tbeat_t b;
    b.data  = 32'hC000_0000 | (ch << 16) | (pkt << 8) | idx;
    b.err   = 6'(ch * 7 + idx);
    b.empty = 2'(idx);
    b.sop   = sop;
    b.eop   = eop;
    return b;
  endfunction

  task automatic push_pkt(int ch, int pkt, int len);
    for (int i = 0; i < len; i++) srcq[ch].push_back(mk(ch, pkt, i, i == 0, i == len - 1));
  endtask

  task automatic flush_srcs();
    for (int k = 0; k < N; k++) srcq[k].delete();
  endtask

  task automatic drive_pins();
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0) begin
        in_valid[k]         = 1'b1;
        in_data[32*k +: 32] = srcq[k][0].data;
        in_error[6*k +: 6]  = srcq[k][0].err;
        in_empty[2*k +: 2]  = srcq[k][0].empty;
        in_sop[k]           = srcq[k][0].sop;
        in_eop[k]           = srcq[k][0].eop;
      end else begin
        in_valid[k]         = 1'b0;
        in_data[32*k +: 32] = '0;
        in_error[6*k +: 6]  = '0;
        in_empty[2*k +: 2]  = '0;
        in_sop[k]           = 1'b0;
        in_eop[k]           = 1'b0;
      end
    end
    out_ready = ordy_next;
  endtask

  always @(posedge clk) begin
    if (!reset)
      for (int k = 0; k < N; k++) if (drv_fire[k]) void'(srcq[k].pop_front());
    #1;
    drive_pins();
  end

  // Reference model: who owns the output, where the search starts, what the output holds.
  int     m_owner = -1;
  int     m_ptr = 0;
  logic   m_ov = 1'b0;
  tbeat_t m_beat = '0;
  int     m_ch = 0;
  logic   m_perr = 1'b0;
  logic   p_acc = 1'b0;
  int     p_k = 0;
  tbeat_t p_beat = '0;
  logic   p_drain = 1'b0;

  function automatic logic [N-1:0] exp_ready_f();
    logic [N-1:0] r = '0;
    bit free = !m_ov || out_ready;
    if (m_owner >= 0) r[m_owner] = free;
    else begin
      for (int i = 0; i < N; i++) begin
        int k = (m_ptr + i) % N;
        if (in_valid[k]) begin
          r[k] = free;
          break;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_ov = 1'b0; m_beat = '0; m_ch = 0; m_perr = 1'b0;
      p_acc = 1'b0; p_drain = 1'b0;
    end else begin
      if (p_acc) begin
        if ((m_owner >= 0 && p_beat.sop) || (m_owner < 0 && !p_beat.sop)) m_perr = 1'b1;
        m_ov = 1'b1; m_beat = p_beat; m_ch = p_k;
        if (p_beat.eop) begin
          m_owner = -1;
          m_ptr = (p_k + 1) % N;
        end else m_owner = p_k;
      end else if (p_drain) m_ov = 1'b0;
      p_acc = 1'b0;
    end
  end

  int log_ch[$];
  int log_cyc[$];
  int cyc = 0;
  int stall0_cnt = 0;

  always @(negedge clk) begin
    logic [N-1:0] er;
    if (reset) begin
      chk("rst_in_ready", in_ready, '0);
      chk("rst_out_valid", out_valid, 0);
      drv_fire = '0;
      p_acc = 1'b0;
    end else begin
      er = exp_ready_f();
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, m_ov);
      chk("protocol_err", protocol_err, m_perr);
      if (m_ov) begin
        chk("out_data", out_data, m_beat.data);
        chk("out_error", out_error, m_beat.err);
        chk("out_empty", out_empty, m_beat.empty);
        chk("out_sop", out_sop, m_beat.sop);
        chk("out_eop", out_eop, m_beat.eop);
        chk("out_channel", out_channel, m_ch);
      end
      p_acc = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (in_valid[k] && er[k]) begin
          p_acc = 1'b1; p_k = k;
          p_beat.data  = in_data[32*k +: 32];
          p_beat.err   = in_error[6*k +: 6];
          p_beat.empty = in_empty[2*k +: 2];
          p_beat.sop   = in_sop[k];
          p_beat.eop   = in_eop[k];
        end
      end
      p_drain  = out_ready;
      drv_fire = in_valid & in_ready;
      if (in_valid[0] && !in_ready[0]) stall0_cnt++;
      if (out_valid && out_ready) begin
        log_ch.push_back(int'(out_channel));
        log_cyc.push_back(cyc);
      end
      cyc++;
    end
  end

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    bit done = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
      done = 1;
      for (int k = 0; k < N; k++) if (srcq[k].size() > 0) done = 0;
      if (out_valid) done = 0;
    end
    chk(name, done, 1);
  endtask

  task automatic wait_ov(input string name, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < max);
    chk(name, out_valid, 1);
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_len"}, log_ch.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_ch.size(); i++)
      chk($sformatf("%s[%0d]", name, i), log_ch[i], exp[i]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    flush_srcs();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[$];
    reset = 1'b1;
    in_valid = '0; in_data = '0; in_error = '0; in_sop = '0; in_eop = '0; in_empty = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("t0_out_valid", out_valid, 0);
    chk("t0_out_data", out_data, 0);
    chk("t0_out_error", out_error, 0);
    chk("t0_out_channel", out_channel, 0);
    chk("t0_sop_eop_empty", {out_sop, out_eop, out_empty}, 0);
    chk("t0_protocol_err", protocol_err, 0);
    chk("t0_in_ready", in_ready, 0);
    reset = 1'b0;

    // Two simultaneous 3-beat packets: whole packets, no interleave.
    @(negedge clk);
    log_ch.delete(); log_cyc.delete();
    push_pkt(0, 1, 3);
    push_pkt(1, 2, 3);
    wait_drain("t1_drain", 40);
    e = '{0, 0, 0, 1, 1, 1};
    chk_log("t1_seq", e);

    // Input0 arrives while input1 is mid-packet and must wait for its EOP.
    @(negedge clk);
    log_ch.delete(); log_cyc.delete();
    push_pkt(1, 3, 3);
    wait_ov("t2_first", 20);
    stall0_cnt = 0;
    push_pkt(0, 4, 3);
    wait_drain("t2_drain", 40);
    chk("t2_stall0_seen", stall0_cnt > 0, 1);
    e = '{1, 1, 1, 0, 0, 0};
    chk_log("t2_seq", e);

    // Downstream backpressure for 5 cycles: held beat stable, every input stalled.
    @(negedge clk);
    log_ch.delete(); log_cyc.delete();
    ordy_next = 1'b0;
    push_pkt(2, 3, 3);
    wait_ov("t3_first", 20);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_data", out_data, 32'hC002_0300);
      chk("t3_hold_chan", out_channel, 2);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_stalled", in_ready, 0);
      @(negedge clk);
    end
    ordy_next = 1'b1;
    wait_drain("t3_drain", 40);
    e = '{2, 2, 2};
    chk_log("t3_seq", e);

    // All four inputs stream single-beat packets: strict rotation, one beat per cycle.
    do_reset();
    @(negedge clk);
    log_ch.delete(); log_cyc.delete();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < N; k++) srcq[k].push_back(mk(k, 5 + p, 0, 1, 1));
    wait_drain("t4_drain", 40);
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_log("t4_seq", e);
    for (int i = 1; i < log_cyc.size(); i++)
      chk("t4_back_to_back", log_cyc[i] - log_cyc[i-1], 1);

    // SOP repeated without EOP: sticky error the cycle after the offending beat.
    do_reset();
    @(negedge clk);
    srcq[0].push_back(mk(0, 7, 0, 1, 0));
    srcq[0].push_back(mk(0, 7, 1, 1, 0));
    srcq[0].push_back(mk(0, 7, 2, 0, 1));
    wait_ov("t5_first", 20);
    chk("t5_perr_before", protocol_err, 0);
    @(negedge clk);
    chk("t5_second_beat", out_data, 32'hC000_0701);
    chk("t5_perr_after", protocol_err, 1);
    wait_drain("t5_drain", 40);
    repeat (3) @(negedge clk);
    chk("t5_perr_sticky", protocol_err, 1);
    do_reset();
    @(negedge clk);
    chk("t5_perr_cleared", protocol_err, 0);

    // Beat in IDLE without SOP also flags.
    srcq[3].push_back(mk(3, 8, 0, 0, 1));
    wait_drain("t5b_drain", 40);
    chk("t5b_perr_nosop", protocol_err, 1);

    // Reset mid-packet drops everything; input0 wins afterwards.
    do_reset();
    @(negedge clk);
    push_pkt(1, 9, 3);
    wait_ov("t6_first", 20);
    @(posedge clk);
    #3 reset = 1'b1;
    flush_srcs();
    #1;
    chk("t6_async_out_valid", out_valid, 0);
    chk("t6_async_in_ready", in_ready, 0);
    push_pkt(0, 10, 3);
    push_pkt(1, 11, 3);
    log_ch.delete(); log_cyc.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    wait_drain("t6_drain", 40);
    e = '{0, 0, 0, 1, 1, 1};
    chk_log("t6_seq", e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
